// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit: decoupled instruction-fetch front end.
//
// Issues word fetches to a 1-cycle-latency synchronous instruction memory and queues each
// returned instruction with its PC in a small FIFO. Decode consumes the FIFO head over a
// valid/ready handshake. A redirect flushes the FIFO, squashes any in-flight response and
// restarts fetch at the (word-aligned) redirect target.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   - with the FIFO empty, a returning response is presented combinationally in
//               its data cycle (1-cycle latency); it is only written if decode stalls.
//   undefined - outputs come purely from the registered FIFO head (2-cycle latency).
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   imem_en        fetch request this cycle
//   imem_addr      word address of the request
//   imem_rdata     instruction, valid the cycle after imem_en
//   redirect_valid flush and restart fetch at redirect_pc
//   redirect_pc    new fetch target (low two bits ignored)
//   if_valid       head instruction valid
//   if_instr       head instruction
//   if_pc          head PC
//   if_pc4         head PC + 4
//   id_ready       decode accepts the head this cycle
//   fifo_count     occupied FIFO entries

module risc_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_AW    = 10,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_en,
  output logic [IMEM_AW-1:0]            imem_addr,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          if_valid,
  output logic [31:0]                   if_instr,
  output logic [XLEN-1:0]               if_pc,
  output logic [XLEN-1:0]               if_pc4,
  input  logic                          id_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     instr_buf_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_buf_q    [FIFO_DEPTH];

  logic credit_ok;
  logic issue;
  logic head_valid;
  logic bypass;
  logic bypass_take;
  logic pop;
  logic push;
  logic wr_en;

  // Credit counts the in-flight response as occupied so a response always has a free slot.
  // A pop in the same cycle deliberately does not free credit.
  assign credit_ok  = (32'(count_q) + 32'(pending_q)) < FIFO_DEPTH;
  assign issue      = rst & ~redirect_valid & credit_ok;
  assign head_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = pending_q & ~redirect_valid & ~head_valid;
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass & id_ready;
  assign pop         = head_valid & id_ready;
  // A bypassed response accepted by decode never enters the FIFO.
  assign push        = pending_q & ~bypass_take;
  assign wr_en       = rst & ~redirect_valid & push;

  assign imem_en    = issue;
  assign imem_addr  = fetch_pc_q[IMEM_AW+1:2];
  assign fifo_count = count_q;

  // Next-state: redirect outranks pop, push and issue.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = issue;
    pending_pc_d = pending_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      pending_d  = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (issue) begin
        fetch_pc_d   = fetch_pc_q + XLEN'(4);
        pending_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_buf_q[wr_ptr_q] <= imem_rdata;
      pc_buf_q[wr_ptr_q]    <= pending_pc_q;
    end
  end

  always_comb begin
    if_instr = '0;
    if_pc    = '0;
    if (head_valid) begin
      if_instr = instr_buf_q[rd_ptr_q];
      if_pc    = pc_buf_q[rd_ptr_q];
    end else if (bypass) begin
      if_instr = imem_rdata;
      if_pc    = pending_pc_q;
    end
  end

  assign if_valid = head_valid | bypass;
  assign if_pc4   = if_valid ? (if_pc + XLEN'(4)) : '0;

`ifndef SYNTHESIS
  // The credit rule must make a write into a full FIFO impossible.
  write_when_full_a : assert property (@(posedge clk) disable iff (!rst)
    !(wr_en && (count_q == CntW'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Testbench for risc_fetch_unit: directed scenarios plus randomized traffic checked against
// a queue-based behavioural model of the fetch front end.

module tb_risc_fetch_unit;

  localparam int          XLEN  = 32;
  localparam int          AW    = 10;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          rv = 1'b0;
  logic [31:0]   rpc = '0;
  logic          if_valid;
  logic [31:0]   if_instr, if_pc, if_pc4;
  logic          rdy = 1'b0;
  logic [2:0]    fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [1024];

  risc_fetch_unit #(
    .XLEN(XLEN), .IMEM_AW(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(rv), .redirect_pc(rpc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .id_ready(rdy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory; garbage on cycles without a request.
  always @(posedge clk) imem_rdata <= imem_en ? mem[imem_addr] : $urandom;

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_ppc = '0;
  logic [31:0] m_fpc = '0;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[(pc >> 2) & 32'h3FF];
  endfunction
  function automatic bit m_byp();
    return BYP && m_pend && !rv && (mq.size() == 0);
  endfunction
  function automatic bit m_valid();
    return (mq.size() > 0) || m_byp();
  endfunction
  function automatic logic [31:0] m_instr();
    if (mq.size() > 0) return mq[0].instr;
    if (m_byp()) return word_at(m_ppc);
    return '0;
  endfunction
  function automatic logic [31:0] m_pc();
    if (mq.size() > 0) return mq[0].pc;
    if (m_byp()) return m_ppc;
    return '0;
  endfunction
  function automatic bit m_en();
    return rst && !rv && ((mq.size() + int'(m_pend)) < DEPTH);
  endfunction

  // Advance model by one clock using current inputs, then let the DUT take the same edge.
  task automatic tick();
    bit   issue, take;
    ent_t e;
    if (!rst) begin
      mq.delete(); m_pend = 1'b0; m_fpc = RPC;
    end else if (rv) begin
      mq.delete(); m_pend = 1'b0; m_fpc = {rpc[31:2], 2'b00};
    end else begin
      issue = m_en();
      take  = m_byp() && rdy;
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (m_pend && !take) begin
        e.instr = word_at(m_ppc); e.pc = m_ppc; mq.push_back(e);
      end
      if (issue) begin m_ppc = m_fpc; m_fpc = m_fpc + 32'd4; end
      m_pend = issue;
    end
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic r, input logic v, input logic [31:0] p, input logic d);
    rst = r; rv = v; rpc = p; rdy = d; #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drv(1'b0, 1'b0, 32'h0, 1'b0); tick(); tick();
    n_checks++;
    if ({if_valid, fifo_count, imem_en} !== 5'b0)
      $display("FAIL reset_ctrl got v=%0b cnt=%0d en=%0b want 0/0/0", if_valid, fifo_count, imem_en);
    else n_pass++;
    n_checks++;
    if ({if_instr, if_pc, if_pc4} !== 96'h0)
      $display("FAIL reset_data got i=%h pc=%h pc4=%h want 0", if_instr, if_pc, if_pc4);
    else n_pass++;
  endtask

  task automatic test_stream();
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({imem_en, imem_addr} !== {1'b1, 10'h0})
      $display("FAIL stream_req got en=%0b addr=%h want 1/000", imem_en, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({if_valid, if_instr} !== {BYP, (BYP ? 32'hA000_0000 : 32'h0)})
      $display("FAIL stream_lat got v=%0b i=%h want v=%0b", if_valid, if_instr, BYP);
    else n_pass++;
    tick();
    for (int k = int'(BYP); k < int'(BYP) + 6; k++) begin
      n_checks++;
      if ({if_valid, if_instr, if_pc, if_pc4} !==
          {1'b1, 32'hA000_0000 + 32'(k), 32'(4 * k), 32'(4 * k + 4)})
        $display("FAIL stream_%0d got v=%0b i=%h pc=%h pc4=%h want i=%h pc=%h", k,
                 if_valid, if_instr, if_pc, if_pc4, 32'hA000_0000 + 32'(k), 32'(4 * k));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    drv(1'b0, 1'b0, 32'h0, 1'b0); tick();
    drv(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) tick();
    n_checks++;
    if ({fifo_count, imem_en, if_valid, if_instr, if_pc} !== {3'd4, 1'b0, 1'b1, 32'hA000_0000, 32'h0})
      $display("FAIL full_hold got cnt=%0d en=%0b v=%0b i=%h pc=%h want 4/0/1/A0000000/0",
               fifo_count, imem_en, if_valid, if_instr, if_pc);
    else n_pass++;
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({if_valid, if_instr, if_pc} !== {1'b1, 32'hA000_0000 + 32'(k), 32'(4 * k)})
        $display("FAIL drain_%0d got v=%0b i=%h pc=%h want i=%h", k, if_valid, if_instr, if_pc,
                 32'hA000_0000 + 32'(k));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    drv(1'b1, 1'b1, 32'h40, 1'b1);
    n_checks++;
    if (imem_en !== 1'b0) $display("FAIL redir_noissue got en=%0b want 0", imem_en);
    else n_pass++;
    tick();
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({if_valid, fifo_count, imem_en, imem_addr} !== {1'b0, 3'd0, 1'b1, 10'h010})
      $display("FAIL redir_flush got v=%0b cnt=%0d en=%0b addr=%h want 0/0/1/010",
               if_valid, fifo_count, imem_en, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (if_valid !== BYP) $display("FAIL redir_lat got v=%0b want %0b", if_valid, BYP);
    else n_pass++;
    if (!if_valid) tick();
    n_checks++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'hA000_0010, 32'h40})
      $display("FAIL redir_first got v=%0b i=%h pc=%h want A0000010/40", if_valid, if_instr, if_pc);
    else n_pass++;
    tick();
    n_checks++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'hA000_0011, 32'h44})
      $display("FAIL redir_next got v=%0b i=%h pc=%h want A0000011/44", if_valid, if_instr, if_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_pop();
    drv(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10 && mq.size() != 3; i++) tick();
    n_checks++;
    if (fifo_count !== 3'd3) $display("FAIL rp_fill got cnt=%0d want 3", fifo_count);
    else n_pass++;
    drv(1'b1, 1'b1, 32'h80, 1'b1); tick();
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({fifo_count, if_valid} !== {3'd0, 1'b0})
      $display("FAIL rp_flush got cnt=%0d v=%0b want 0/0", fifo_count, if_valid);
    else n_pass++;
    for (int i = 0; i < 4 && !if_valid; i++) tick();
    n_checks++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'hA000_0020, 32'h80})
      $display("FAIL rp_first got v=%0b i=%h pc=%h want A0000020/80", if_valid, if_instr, if_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drv(1'b1, 1'b1, 32'hFFC, 1'b1); tick();
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({imem_en, imem_addr} !== {1'b1, 10'h3FF})
      $display("FAIL wrap_a0 got en=%0b addr=%h want 1/3FF", imem_en, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({imem_en, imem_addr} !== {1'b1, 10'h000})
      $display("FAIL wrap_a1 got en=%0b addr=%h want 1/000", imem_en, imem_addr);
    else n_pass++;
    for (int i = 0; i < 4 && !if_valid; i++) tick();
    n_checks++;
    if ({if_valid, if_instr, if_pc, if_pc4} !== {1'b1, 32'hA000_03FF, 32'hFFC, 32'h1000})
      $display("FAIL wrap_d0 got v=%0b i=%h pc=%h pc4=%h want A00003FF/FFC/1000",
               if_valid, if_instr, if_pc, if_pc4);
    else n_pass++;
    tick();
    n_checks++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'hA000_0000, 32'h1000})
      $display("FAIL wrap_d1 got v=%0b i=%h pc=%h want A0000000/1000", if_valid, if_instr, if_pc);
    else n_pass++;
    drv(1'b1, 1'b1, 32'hFFE, 1'b1); tick();
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({imem_en, imem_addr} !== {1'b1, 10'h3FF})
      $display("FAIL align_addr got en=%0b addr=%h want 1/3FF", imem_en, imem_addr);
    else n_pass++;
    for (int i = 0; i < 4 && !if_valid; i++) tick();
    n_checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'hFFC})
      $display("FAIL align_pc got v=%0b pc=%h want FFC", if_valid, if_pc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10 && mq.size() != 2; i++) tick();
    n_checks++;
    if (fifo_count !== 3'd2) $display("FAIL rm_fill got cnt=%0d want 2", fifo_count);
    else n_pass++;
    drv(1'b0, 1'b0, 32'h0, 1'b0); tick();
    n_checks++;
    if ({if_valid, fifo_count, imem_en} !== 5'b0)
      $display("FAIL rm_clear got v=%0b cnt=%0d en=%0b want 0/0/0", if_valid, fifo_count, imem_en);
    else n_pass++;
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({imem_en, imem_addr} !== {1'b1, 10'h0})
      $display("FAIL rm_restart got en=%0b addr=%h want 1/000", imem_en, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({if_valid, if_instr} !== {BYP, (BYP ? 32'hA000_0000 : 32'h0)})
      $display("FAIL rm_lat got v=%0b i=%h want v=%0b", if_valid, if_instr, BYP);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] p, ep;
    for (int c = 0; c < 600; c++) begin
      p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drv(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0), p,
          ($urandom_range(0, 9) < 7));
      ep = m_pc();
      n_checks++;
      if ({imem_en, if_valid, fifo_count} !== {m_en(), m_valid(), 3'(mq.size())})
        $display("FAIL rnd_ctrl_%0d got en=%0b v=%0b cnt=%0d want %0b/%0b/%0d", c, imem_en,
                 if_valid, fifo_count, m_en(), m_valid(), mq.size());
      else n_pass++;
      n_checks++;
      if ({if_instr, if_pc, if_pc4} !== {m_instr(), ep, (m_valid() ? ep + 32'd4 : 32'h0)})
        $display("FAIL rnd_data_%0d got i=%h pc=%h pc4=%h want i=%h pc=%h", c, if_instr, if_pc,
                 if_pc4, m_instr(), ep);
      else n_pass++;
      if (m_en()) begin
        n_checks++;
        if (imem_addr !== m_fpc[11:2])
          $display("FAIL rnd_addr_%0d got %h want %h", c, imem_addr, m_fpc[11:2]);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 + 32'(k);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of run");
    $fatal(1);
  end

endmodule
